// File: rtl/rv32_timer_pkg.sv
// ----------------------------------------------------------------------------
// rv32_timer_pkg
//   Shared definitions for the memory-mapped machine timer:
//     - timer_word_e : word offsets within the 32-byte register window
//                      (address_in[4:2]).
//     - CTRL bit indices for the enable and irq_enable flags.
//     - byte_merge() : byte-enable merge of a write into an existing word.
// ----------------------------------------------------------------------------
package rv32_timer_pkg;

    // Word select, taken from address_in[4:2].
    typedef enum logic [2:0] {
        TIMER_MTIME_LO = 3'd0,
        TIMER_MTIME_HI = 3'd1,
        TIMER_CMP_LO   = 3'd2,
        TIMER_CMP_HI   = 3'd3,
        TIMER_CTRL     = 3'd4,
        TIMER_PRESCALE = 3'd5,
        TIMER_STATUS   = 3'd6,
        TIMER_RSVD     = 3'd7
    } timer_word_e;

    // CTRL register layout.
    localparam int unsigned CTRL_WIDTH       = 2;
    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 1;

    // Replace each byte of old_word whose mask bit is set with the
    // corresponding byte of new_word; a zero mask returns old_word.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  mask
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/rv32_timer_prescaler.sv
// ----------------------------------------------------------------------------
// rv32_timer_prescaler
//   Down-counter that produces one tick per (reload + 1) enabled cycles.
//   Ports:
//     clk, reset  - clock and asynchronous active-high reset
//     enable      - counter advances only when high; holds otherwise
//     reload      - value loaded when the count expires or on restart
//     restart     - forces a reload and masks the tick for this cycle
//     tick        - high in a cycle where the timer should increment
//   The reload value is only sampled when a reload happens, so a new
//   prescale setting never disturbs a count already in flight.
// ----------------------------------------------------------------------------
module rv32_timer_prescaler #(
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] reload,
    input  logic                      restart,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] count_r;
    logic [PRESCALE_WIDTH-1:0] count_nxt_s;
    logic                      expired_s;

    // Count has reached zero and is ready to emit a tick.
    always_comb begin
        expired_s = (count_r == {PRESCALE_WIDTH{1'b0}});
    end

    // Tick is masked while a restart is pending (the mtime write wins).
    always_comb begin
        if (restart) begin
            tick = 1'b0;
        end else begin
            tick = enable & expired_s;
        end
    end

    // Next count: restart reload, expiry reload, decrement, or hold.
    always_comb begin
        count_nxt_s = count_r;
        if (restart) begin
            count_nxt_s = reload;
        end else if (enable) begin
            if (expired_s) begin
                count_nxt_s = reload;
            end else begin
                count_nxt_s = count_r - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {PRESCALE_WIDTH{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/rv32_timer.sv
// ----------------------------------------------------------------------------
// rv32_timer
//   Memory-mapped machine timer on the core's single-cycle data bus.
//   Holds a 64-bit prescaled free-running mtime, a 64-bit mtimecmp and a
//   registered level interrupt.
//   Ports:
//     clk, reset      - clock and asynchronous active-high reset
//     sel_in          - address decode hit; bus strobes ignored when low
//     address_in[4:0] - byte address; [4:2] selects the word, [1:0] unused
//     read_in         - read strobe
//     write_in        - write strobe
//     write_mask_in   - byte enables for write_value_in
//     write_value_in  - write data
//     read_value_out  - combinational read data (0 when not reading)
//     irq_out         - irq_enable & (mtime >= mtimecmp), one cycle late
//   Register map (word offsets): 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 CMP_LO,
//   0x0C CMP_HI, 0x10 CTRL {irq_enable, enable}, 0x14 PRESCALE,
//   0x18 STATUS (ro, bit0 = mtime >= mtimecmp), 0x1C reserved.
//   PRESCALE_WIDTH must not exceed 32 (the register lives in one word).
// ----------------------------------------------------------------------------
module rv32_timer
    import rv32_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_WIDTH = 16,
    parameter logic [63:0] CMP_RESET      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_in,
    input  logic [4:0]  address_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        irq_out
);

    timer_word_e               word_s;
    logic [1:0]                unused_addr_s;
    logic                      wr_en_s;
    logic                      mtime_wr_s;
    logic                      tick_s;
    logic                      cmp_ge_s;
    logic [31:0]               cur_word_s;
    logic [31:0]               merged_s;

    logic [63:0]               mtime_r;
    logic [63:0]               mtime_nxt_s;
    logic [63:0]               cmp_r;
    logic [63:0]               cmp_nxt_s;
    logic [CTRL_WIDTH-1:0]     ctrl_r;
    logic [CTRL_WIDTH-1:0]     ctrl_nxt_s;
    logic [PRESCALE_WIDTH-1:0] prescale_r;
    logic [PRESCALE_WIDTH-1:0] prescale_nxt_s;
    logic                      irq_r;

    // Byte offset bits within a word carry no meaning.
    assign unused_addr_s = address_in[1:0];

    // Word select decode.
    always_comb begin
        word_s = timer_word_e'(address_in[4:2]);
    end

    // A write only counts when selected and at least one byte is enabled;
    // this also keeps a zero-mask mtime write from restarting the prescaler.
    always_comb begin
        wr_en_s = sel_in & write_in & (write_mask_in != 4'b0000);
    end

    // Any effective write to either mtime half.
    always_comb begin
        if (wr_en_s && ((word_s == TIMER_MTIME_LO) || (word_s == TIMER_MTIME_HI))) begin
            mtime_wr_s = 1'b1;
        end else begin
            mtime_wr_s = 1'b0;
        end
    end

    // Unsigned 64-bit compare shared by STATUS and the interrupt.
    always_comb begin
        cmp_ge_s = (mtime_r >= cmp_r);
    end

    // Current value of the addressed word, independent of the strobes.
    // Also serves as the "old" value for the byte-masked write merge.
    always_comb begin
        cur_word_s = 32'h0000_0000;
        case (word_s)
            TIMER_MTIME_LO: cur_word_s = mtime_r[31:0];
            TIMER_MTIME_HI: cur_word_s = mtime_r[63:32];
            TIMER_CMP_LO:   cur_word_s = cmp_r[31:0];
            TIMER_CMP_HI:   cur_word_s = cmp_r[63:32];
            TIMER_CTRL:     cur_word_s[CTRL_WIDTH-1:0] = ctrl_r;
            TIMER_PRESCALE: cur_word_s[PRESCALE_WIDTH-1:0] = prescale_r;
            TIMER_STATUS:   cur_word_s[0] = cmp_ge_s;
            default:        cur_word_s = 32'h0000_0000;
        endcase
    end

    // Byte-masked merge of the incoming write into the addressed word.
    always_comb begin
        merged_s = byte_merge(cur_word_s, write_value_in, write_mask_in);
    end

    // Read data path: pre-edge register state, zero when not reading.
    always_comb begin
        if (sel_in && read_in) begin
            read_value_out = cur_word_s;
        end else begin
            read_value_out = 32'h0000_0000;
        end
    end

    // Prescaler; an mtime write restarts it and suppresses that tick.
    rv32_timer_prescaler #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (ctrl_r[CTRL_ENABLE_BIT]),
        .reload  (prescale_r),
        .restart (mtime_wr_s),
        .tick    (tick_s)
    );

    // Next mtime: a write to either half replaces that half and blocks the
    // increment for all 64 bits; otherwise a tick increments with carry.
    always_comb begin
        mtime_nxt_s = mtime_r;
        if (wr_en_s && (word_s == TIMER_MTIME_LO)) begin
            mtime_nxt_s = {mtime_r[63:32], merged_s};
        end else if (wr_en_s && (word_s == TIMER_MTIME_HI)) begin
            mtime_nxt_s = {merged_s, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
    end

    // Next state of the plain configuration registers.
    always_comb begin
        cmp_nxt_s      = cmp_r;
        ctrl_nxt_s     = ctrl_r;
        prescale_nxt_s = prescale_r;
        if (wr_en_s) begin
            case (word_s)
                TIMER_CMP_LO:   cmp_nxt_s      = {cmp_r[63:32], merged_s};
                TIMER_CMP_HI:   cmp_nxt_s      = {merged_s, cmp_r[31:0]};
                TIMER_CTRL:     ctrl_nxt_s     = merged_s[CTRL_WIDTH-1:0];
                TIMER_PRESCALE: prescale_nxt_s = merged_s[PRESCALE_WIDTH-1:0];
                default: begin
                    cmp_nxt_s      = cmp_r;
                    ctrl_nxt_s     = ctrl_r;
                    prescale_nxt_s = prescale_r;
                end
            endcase
        end else begin
            cmp_nxt_s      = cmp_r;
            ctrl_nxt_s     = ctrl_r;
            prescale_nxt_s = prescale_r;
        end
    end

    // Timer and configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime_r    <= 64'd0;
            cmp_r      <= CMP_RESET;
            ctrl_r     <= {CTRL_WIDTH{1'b0}};
            prescale_r <= {PRESCALE_WIDTH{1'b0}};
        end else begin
            mtime_r    <= mtime_nxt_s;
            cmp_r      <= cmp_nxt_s;
            ctrl_r     <= ctrl_nxt_s;
            prescale_r <= prescale_nxt_s;
        end
    end

    // Interrupt flop: level, follows the pre-edge compare result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= ctrl_r[CTRL_IRQ_EN_BIT] & cmp_ge_s;
        end
    end

    assign irq_out = irq_r;

endmodule

// File: doc/rv32_timer.md
Name: rv32_timer

Overview:
- Memory-mapped machine timer sitting directly downstream of the core's data memory bus. Sits alongside data RAM behind the top-level address decode.
- Consumes the core's address, read, write, mask and value outputs. Supplies the read value back on the shared data read path.
- Provides a 64-bit prescaled free-running counter (mtime), a 64-bit compare register (mtimecmp) and a level interrupt.
- Read latency is zero cycles, matching the core's single-cycle data bus.

Parameters:
- PRESCALE_WIDTH, 16, width of prescale reload register and prescale down-counter.
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp (no interrupt after reset).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel_in  in  1  address decode hit for this block; read/write ignored when 0.
- address_in  in  5  byte address within the block; bits [4:2] select the word, bits [1:0] are ignored.
- read_in  in  1  read strobe (core data_read_out).
- write_in  in  1  write strobe (core data_write_out).
- write_mask_in  in  4  byte enables; bit n enables write_value_in[8n+7:8n].
- write_value_in  in  32  write data.
- read_value_out  out  32  read data, combinational from current register state.
- irq_out  out  1  registered timer interrupt.

Behaviour:
- Register map (word offset, access):
  - 0x00 MTIME_LO rw
  - 0x04 MTIME_HI rw
  - 0x08 CMP_LO rw
  - 0x0C CMP_HI rw
  - 0x10 CTRL rw: bit0 = enable, bit1 = irq_enable, other bits read 0.
  - 0x14 PRESCALE rw: low PRESCALE_WIDTH bits, upper bits read 0.
  - 0x18 STATUS ro: bit0 = (mtime >= mtimecmp), unsigned 64-bit compare.
  - 0x1C reserved, reads 0, writes ignored.
- Reset (async, immediate):
  - mtime = 0, mtimecmp = CMP_RESET, CTRL = 0, PRESCALE = 0.
  - Prescale counter = 0, irq_out = 0.
  - read_value_out follows the reset register state combinationally.
- Reads:
  - read_value_out = selected register when sel_in & read_in, else 0.
  - Value reflects state before the current clock edge.
  - No side effects on read.
- Writes (sel_in & write_in at a clock edge):
  - Byte-masked merge into the addressed register.
  - Mask 0 means no change.
  - Writes to STATUS and reserved words are ignored.
- Prescaler:
  - When CTRL.enable = 0: counter holds and mtime holds.
  - When enabled and counter == 0: mtime += 1 (full 64-bit, carry lo->hi), counter reloads with PRESCALE.
  - When enabled and counter != 0: counter -= 1.
  - PRESCALE = 0 gives an increment every enabled cycle. PRESCALE = N gives one increment per N+1 cycles.
- Simultaneous events:
  - A write to MTIME_LO or MTIME_HI (any nonzero mask) suppresses that cycle's increment for the whole 64 bits.
  - The same write reloads the prescale counter with PRESCALE. The unwritten half keeps its old value.
  - A write to PRESCALE takes effect at the next reload; the in-flight count is not altered.
  - Setting CTRL.enable 0->1 does not reset the counter.
- Wrap-around: mtime 0xFFFF_FFFF_FFFF_FFFF + 1 = 0. No sticky flag.
- Interrupt:
  - irq_out <= CTRL.irq_enable & (mtime >= mtimecmp), registered, so 1 cycle after the condition.
  - Level, not sticky. Cleared by writing a larger mtimecmp, clearing irq_enable, or writing mtime lower.
- read_in and write_in both high: write happens at the edge; read returns the pre-write value.

Decomposition:
- Package rv32_timer_pkg:
  - Word offset constants TIMER_MTIME_LO..TIMER_STATUS.
  - CTRL bit index constants.
  - Byte-mask merge function (old, new, mask) -> merged.
- Sub-module rv32_timer_prescaler (enable, reload value, restart strobe -> tick output).
- Top holds registers, the read mux, the compare and the irq flop.

Test Plan:
- Reset mid-count: reset asserted between edges -> read_value_out at 0x00 = 0 and irq_out = 0 immediately; CMP_LO reads 0xFFFF_FFFF.
- PRESCALE = 3, CTRL = 1, count 12 cycles -> MTIME_LO = 3; with PRESCALE = 0, 12 cycles -> 12.
- Carry: write MTIME_LO = 0xFFFF_FFFF, MTIME_HI = 0, enable, PRESCALE = 0 -> after 1 cycle LO = 0, HI = 1; HI = 0xFFFF_FFFF too -> both wrap to 0.
- Interrupt: CMP = 10, CTRL = 3, PRESCALE = 0 from mtime 0 -> STATUS.bit0 rises when mtime = 10, irq_out one cycle later; write CMP_LO = 100 -> irq_out drops one cycle after the write.
- Byte mask: write 0x1234_5678 mask 0b0101 to CMP_LO (was 0xFFFF_FFFF) -> reads 0xFF34_FF78; mask 0 -> unchanged; sel_in = 0 -> unchanged, read 0.
- Write vs tick collision: enabled, PRESCALE = 0, write MTIME_LO = 5 on a tick cycle -> reads 5 the next cycle, then 6.
